// File: rtl/riscv_wbarb_pkg.sv
// Shared types and sizes for the register-file writeback arbiter.
// Writeback source indices match the requester bit positions on the arbiter ports.
package riscv_wbarb_pkg;

  localparam int XLEN       = 64;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_LSU = 2'd1,
    WB_MDU = 2'd2
  } wb_src_e;

endpackage

// File: rtl/riscv_rr_arbiter.sv
// N-way arbiter with a one-hot grant (combinational) and a rotating priority pointer (registered).
// RISCV_WBARB_FIXED_PRIO_EN selects fixed lowest-index priority, with the pointer tied to 0.
module riscv_rr_arbiter #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] gidx;
  logic [PW:0]   pos;
  logic [PW-1:0] idx;
  logic          found;

  // Walk the requesters starting at the pointer, wrapping mod N; the first hit wins.
  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    pos   = '0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      pos = {1'b0, ptr} + (PW+1)'(i);
      if (pos >= (PW+1)'(N)) begin
        pos = pos - (PW+1)'(N);
      end
      idx = pos[PW-1:0];
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        gidx       = idx;
        found      = 1'b1;
      end
    end
  end

`ifdef RISCV_WBARB_FIXED_PRIO_EN
  logic unused_fixed_prio;
  assign unused_fixed_prio = rst ^ clear ^ advance ^ (^gidx);

  always_ff @(posedge clk) begin
    ptr <= '0;
  end
`else
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (gidx == PW'(N-1)) ? '0 : gidx + 1'b1;
    end
  end
`endif

endmodule

// File: rtl/riscv_rf_wb_arbiter.sv
// Shares the rf write port among NREQ writeback sources; registered write one cycle after grant,
// plus a pending-write scoreboard. RISCV_WBARB_FIXED_PRIO_EN switches round-robin to fixed priority.
module riscv_rf_wb_arbiter #(
  parameter int NREQ  = 3,
  parameter int XLEN  = 64,
  parameter int ADDRW = 5
) (
  input  logic                  i_riscv_wbarb_clk,
  input  logic                  i_riscv_wbarb_rst,
  input  logic [NREQ-1:0]       i_riscv_wbarb_req_valid,
  output logic [NREQ-1:0]       o_riscv_wbarb_req_ready,
  input  logic [NREQ*ADDRW-1:0] i_riscv_wbarb_req_rdaddr,
  input  logic [NREQ*XLEN-1:0]  i_riscv_wbarb_req_rddata,
  input  logic                  i_riscv_wbarb_issue_valid,
  input  logic [ADDRW-1:0]      i_riscv_wbarb_issue_rdaddr,
  input  logic                  i_riscv_wbarb_flush,
  output logic                  o_riscv_wbarb_rf_regwrite,
  output logic [ADDRW-1:0]      o_riscv_wbarb_rf_rdaddr,
  output logic [XLEN-1:0]       o_riscv_wbarb_rf_rddata,
  output logic [31:0]           o_riscv_wbarb_busy
);

  import riscv_wbarb_pkg::*;

  typedef struct packed {
    logic [ADDRW-1:0] addr;
    logic [XLEN-1:0]  data;
  } wr_t;

  logic [NREQ-1:0]     req_gated;
  logic [NREQ-1:0]     grant;
  logic                xfer;
  wr_t                 sel;
  wr_t                 wr_q;
  logic                regwrite_q;
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_nxt;

  // No grants while in reset or during a flush cycle.
  assign req_gated = i_riscv_wbarb_req_valid
                   & {NREQ{~(i_riscv_wbarb_rst | i_riscv_wbarb_flush)}};

  riscv_rr_arbiter #(
    .N (NREQ)
  ) u_arb (
    .clk     (i_riscv_wbarb_clk),
    .rst     (i_riscv_wbarb_rst),
    .clear   (i_riscv_wbarb_flush),
    .req     (req_gated),
    .advance (xfer),
    .grant   (grant)
  );

  assign xfer = |grant;

  always_comb begin
    sel = '0;
    for (int r = 0; r < NREQ; r++) begin
      if (grant[r]) begin
        sel.addr = i_riscv_wbarb_req_rdaddr[r*ADDRW +: ADDRW];
        sel.data = i_riscv_wbarb_req_rddata[r*XLEN +: XLEN];
      end
    end
  end

  // An x0 result is accepted but never turns into an rf write.
  always_ff @(posedge i_riscv_wbarb_clk) begin
    if (i_riscv_wbarb_rst) begin
      regwrite_q <= 1'b0;
      wr_q       <= '0;
    end else if (xfer) begin
      regwrite_q <= (sel.addr != '0);
      wr_q       <= sel;
    end else begin
      regwrite_q <= 1'b0;
    end
  end

  // Set is applied after clear so a same-cycle issue to the committing reg stays busy.
  always_comb begin
    busy_nxt = busy_q;
    if (xfer) begin
      busy_nxt[sel.addr] = 1'b0;
    end
    if (i_riscv_wbarb_issue_valid && (i_riscv_wbarb_issue_rdaddr != '0)) begin
      busy_nxt[i_riscv_wbarb_issue_rdaddr] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge i_riscv_wbarb_clk) begin
    if (i_riscv_wbarb_rst || i_riscv_wbarb_flush) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_nxt;
    end
  end

  assign o_riscv_wbarb_req_ready   = grant;
  assign o_riscv_wbarb_rf_regwrite = regwrite_q;
  assign o_riscv_wbarb_rf_rdaddr   = wr_q.addr;
  assign o_riscv_wbarb_rf_rddata   = wr_q.data;
  assign o_riscv_wbarb_busy        = busy_q;

  a_grant_onehot: assert property (@(posedge i_riscv_wbarb_clk)
    $onehot0(grant) && ((grant & ~i_riscv_wbarb_req_valid) == '0));

  // The hazard unit must stall issue on a reg that still has a write pending.
  a_no_double_issue: assert property (@(posedge i_riscv_wbarb_clk)
    disable iff (i_riscv_wbarb_rst || i_riscv_wbarb_flush)
    (i_riscv_wbarb_issue_valid && (i_riscv_wbarb_issue_rdaddr != '0))
      |-> !busy_q[i_riscv_wbarb_issue_rdaddr]);

endmodule

// File: tb/tb_riscv_rf_wb_arbiter.sv
// Directed bench for riscv_rf_wb_arbiter: expected rf writes are queued at grant time and
// popped by an independent monitor; grant/busy/flush behaviour is checked inline.
module tb_riscv_rf_wb_arbiter;

  import riscv_wbarb_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   valid;
  logic [2:0]   ready;
  logic [14:0]  rdaddr_bus;
  logic [191:0] rddata_bus;
  logic         issue_valid;
  logic [4:0]   issue_rdaddr;
  logic         flush;
  logic         regwrite;
  logic [4:0]   rf_rdaddr;
  logic [63:0]  rf_rddata;
  logic [31:0]  busy;

  logic [4:0]   ra [3];
  logic [63:0]  rd [3];

  typedef struct {
    logic [4:0]  a;
    logic [63:0] d;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int r = 0; r < 3; r++) begin
      rdaddr_bus[r*5 +: 5]   = ra[r];
      rddata_bus[r*64 +: 64] = rd[r];
    end
  end

  riscv_rf_wb_arbiter #(
    .NREQ  (3),
    .XLEN  (64),
    .ADDRW (5)
  ) dut (
    .i_riscv_wbarb_clk          (clk),
    .i_riscv_wbarb_rst          (rst),
    .i_riscv_wbarb_req_valid    (valid),
    .o_riscv_wbarb_req_ready    (ready),
    .i_riscv_wbarb_req_rdaddr   (rdaddr_bus),
    .i_riscv_wbarb_req_rddata   (rddata_bus),
    .i_riscv_wbarb_issue_valid  (issue_valid),
    .i_riscv_wbarb_issue_rdaddr (issue_rdaddr),
    .i_riscv_wbarb_flush        (flush),
    .o_riscv_wbarb_rf_regwrite  (regwrite),
    .o_riscv_wbarb_rf_rdaddr    (rf_rdaddr),
    .o_riscv_wbarb_rf_rddata    (rf_rddata),
    .o_riscv_wbarb_busy         (busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare ready with the hand-computed grant and queue the write it must produce.
  task automatic expect_grant(input string name, input logic [2:0] g);
    check(name, 64'(ready), 64'(g));
    for (int r = 0; r < 3; r++) begin
      if (g[r] && (ra[r] != 5'd0)) begin
        exp_q.push_back('{a: ra[r], d: rd[r]});
      end
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (regwrite === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got x%0d=0x%0h, expected no write (t=%0t)",
                 rf_rdaddr, rf_rddata, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("write_addr", 64'(rf_rdaddr), 64'(e.a));
        check("write_data", rf_rddata, e.d);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL timeout: got no end of run, expected finish before 50000");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [2:0] prio_exp [3];

    rst          = 1'b1;
    valid        = 3'b111;
    flush        = 1'b0;
    issue_valid  = 1'b0;
    issue_rdaddr = 5'd0;
    for (int r = 0; r < 3; r++) begin
      ra[r] = 5'(r + 1);
      rd[r] = 64'h0;
    end

    // Reset with every requester valid.
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("rst_ready", 64'(ready), 64'h0);
      check("rst_regwrite", 64'(regwrite), 64'h0);
      check("rst_busy", 64'(busy), 64'h0);
    end
    next_cycle();
    rst = 1'b0;

    // All valid: rotation 0,1,2,0,1,2 starting from req0.
    for (int k = 0; k < 6; k++) begin
      for (int r = 0; r < 3; r++) begin
        rd[r] = 64'h100 * k + 64'(r) + 64'hA000;
      end
      @(negedge clk);
      expect_grant("rr_grant", 3'(1 << (k % 3)));
      next_cycle();
    end
    valid = 3'b000;
    @(negedge clk);
    check("idle_ready", 64'(ready), 64'h0);
    next_cycle();

    // Issue x5; the LSU commits it later.
    issue_valid  = 1'b1;
    issue_rdaddr = 5'd5;
    @(negedge clk);
    check("busy_before_issue_edge", 64'(busy), 64'h0);
    next_cycle();
    issue_valid = 1'b0;
    @(negedge clk);
    check("busy_x5_set", 64'(busy), 64'h20);
    next_cycle();
    valid                 = 3'b010;
    ra[int'(WB_LSU)]      = 5'd5;
    rd[int'(WB_LSU)]      = 64'hDEAD_BEEF;
    @(negedge clk);
    expect_grant("lsu_grant", 3'b010);
    check("busy_x5_until_edge", 64'(busy), 64'h20);
    next_cycle();
    valid = 3'b000;
    @(negedge clk);
    check("busy_x5_cleared", 64'(busy), 64'h0);
    check("rf_rdaddr_x5", 64'(rf_rdaddr), 64'd5);
    check("rf_rddata_x5", rf_rddata, 64'hDEAD_BEEF);
    check("rf_regwrite_x5", 64'(regwrite), 64'h1);
    next_cycle();

    // Issue and commit x7 in the same cycle: set wins. Pointer is 2 here.
    valid        = 3'b001;
    ra[0]        = 5'd7;
    rd[0]        = 64'h77;
    issue_valid  = 1'b1;
    issue_rdaddr = 5'd7;
    @(negedge clk);
    expect_grant("x7_grant", 3'b001);
    next_cycle();
    issue_valid = 1'b0;
    valid       = 3'b010;
    ra[1]       = 5'd0;
    rd[1]       = 64'h55;
    @(negedge clk);
    check("busy_x7_set_wins", 64'(busy), 64'h80);
    expect_grant("x0_grant", 3'b010);
    next_cycle();
    valid = 3'b000;
    @(negedge clk);
    check("x0_no_regwrite", 64'(regwrite), 64'h0);
    check("busy_after_x0", 64'(busy), 64'h80);
    next_cycle();

    // Build busy {x3,x9} (x7 still pending), then a write to x20 right before a flush.
    issue_valid  = 1'b1;
    issue_rdaddr = 5'd3;
    next_cycle();
    issue_rdaddr = 5'd9;
    next_cycle();
    issue_valid = 1'b0;
    valid       = 3'b010;
    ra[1]       = 5'd20;
    rd[1]       = 64'h2020;
    @(negedge clk);
    check("busy_pre_flush", 64'(busy), 64'h288);
    expect_grant("pre_flush_grant", 3'b010);
    next_cycle();

    // Flush with pointer at 2: no grant, issue ignored, registered x20 write still lands.
    flush        = 1'b1;
    valid        = 3'b110;
    ra[1]        = 5'd9;
    rd[1]        = 64'h99;
    ra[2]        = 5'd3;
    rd[2]        = 64'h33;
    issue_valid  = 1'b1;
    issue_rdaddr = 5'd12;
    @(negedge clk);
    check("flush_ready", 64'(ready), 64'h0);
    check("flush_write_completes", 64'(regwrite), 64'h1);
    next_cycle();
    flush       = 1'b0;
    issue_valid = 1'b0;
    @(negedge clk);
    check("post_flush_busy", 64'(busy), 64'h0);
    check("post_flush_regwrite", 64'(regwrite), 64'h0);
    expect_grant("post_flush_grant", 3'b010);
    next_cycle();

    // valid=110 for three cycles, pointer at 2 on entry.
`ifdef RISCV_WBARB_FIXED_PRIO_EN
    prio_exp = '{3'b010, 3'b010, 3'b010};
`else
    prio_exp = '{3'b100, 3'b010, 3'b100};
`endif
    for (int k = 0; k < 3; k++) begin
      rd[1] = 64'h6100 + 64'(k);
      rd[2] = 64'h6200 + 64'(k);
      @(negedge clk);
      expect_grant("prio_grant", prio_exp[k]);
      next_cycle();
    end
    valid = 3'b000;
    @(negedge clk);
    check("final_idle_ready", 64'(ready), 64'h0);
    next_cycle();
    next_cycle();
    check("writes_outstanding", 64'(exp_q.size()), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
